// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: FSM state type and frame field constants shared by the UART frame sequencer.
package uart_frame_pkg;
  typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CHK, HOLD} state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int LEN_W = 4;
endpackage

// File: rtl/uart_frame_ctrl_if.sv
// uart_frame_ctrl_if: byte input, frame valid/ready handoff and error outputs of uart_frame_ctrl.
interface uart_frame_ctrl_if #(
  parameter int MAX_PAYLOAD = 8,
  parameter int ERR_CNT_W   = 8
);
  import uart_frame_pkg::*;
  logic [7:0]               rx_data;
  logic                     rx_ready;
  logic [7:0]               frame_cmd;
  logic [LEN_W-1:0]         frame_len;
  logic [MAX_PAYLOAD*8-1:0] frame_payload;
  logic                     frame_valid;
  logic                     frame_ready;
  logic                     err_chk;
  logic                     err_len;
  logic                     err_overrun;
  logic                     err_timeout;
  logic [ERR_CNT_W-1:0]     err_count;
  modport master (
    output rx_data, rx_ready, frame_ready,
    input  frame_cmd, frame_len, frame_payload, frame_valid,
           err_chk, err_len, err_overrun, err_timeout, err_count
  );
  modport slave (
    input  rx_data, rx_ready, frame_ready,
    output frame_cmd, frame_len, frame_payload, frame_valid,
           err_chk, err_len, err_overrun, err_timeout, err_count
  );
endinterface

// File: rtl/uart_byte_strobe.sv
// uart_byte_strobe: one-cycle strobe on each rising edge of rx_ready, with the byte captured at that edge.
module uart_byte_strobe (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       stb,
  output logic [7:0] data
);
  logic rx_ready_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_ready_q <= 1'b0;
      stb        <= 1'b0;
      data       <= '0;
    end else begin
      rx_ready_q <= rx_ready;
      stb        <= rx_ready & ~rx_ready_q;
      if (rx_ready & ~rx_ready_q) data <= rx_data;
    end
endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: turns the UART byte stream into checksummed command frames with valid/ready handoff
// and error pulses plus a saturating error count; inter-byte timeout only with UART_FRAME_TIMEOUT_EN.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         ERR_CNT_W      = 8,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input logic              clk,
  input logic              reset,
  uart_frame_ctrl_if.slave bus
);
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);
  state_t               state, state_n;
  logic                 stb, tout, hs, e_chk, e_len, e_ovr;
  logic                 r_chk, r_len, r_ovr, r_tmo;
  logic [7:0]           data, cmd, chk;
  logic [LEN_W-1:0]     len, idx;
  logic [7:0]           pbuf [MAX_PAYLOAD];
  logic [ERR_CNT_W-1:0] cnt;

  uart_byte_strobe u_stb (
    .clk(clk), .reset(reset), .rx_ready(bus.rx_ready), .rx_data(bus.rx_data), .stb(stb), .data(data)
  );

  assign hs = bus.frame_valid & bus.frame_ready;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    e_chk   = 1'b0;
    e_len   = 1'b0;
    e_ovr   = 1'b0;
    case (state)
      IDLE:    if (stb && data == SYNC_BYTE) state_n = CMD;
      CMD:     if (stb) state_n = LEN;
      LEN:     if (stb) begin
        e_len   = data > MAX_LEN;
        state_n = e_len ? IDLE : (data == 8'd0) ? CHK : PAYLOAD;
      end
      PAYLOAD: if (stb && idx == len - LEN_W'(1)) state_n = CHK;
      CHK:     if (stb) begin
        e_chk   = data != chk;
        state_n = e_chk ? IDLE : HOLD;
      end
      HOLD: begin
        e_ovr   = stb;
        state_n = hs ? IDLE : HOLD;
      end
      default: state_n = IDLE;
    endcase
    if (tout) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cmd <= '0;
      len <= '0;
      idx <= '0;
      chk <= '0;
      {r_chk, r_len, r_ovr, r_tmo} <= '0;
      cnt <= '0;
      for (int i = 0; i < MAX_PAYLOAD; i++) pbuf[i] <= '0;
    end else begin
      {r_chk, r_len, r_ovr, r_tmo} <= {e_chk, e_len, e_ovr, tout};
      if ((e_chk | e_len | e_ovr | tout) && !(&cnt)) cnt <= cnt + ERR_CNT_W'(1);
      if (stb)
        case (state)
          IDLE:    if (data == SYNC_BYTE) for (int i = 0; i < MAX_PAYLOAD; i++) pbuf[i] <= '0;
          CMD: begin
            cmd <= data;
            chk <= data;
          end
          LEN: begin
            chk <= chk ^ data;
            idx <= '0;
            if (!e_len) len <= data[LEN_W-1:0];
          end
          PAYLOAD: begin
            chk <= chk ^ data;
            idx <= idx + LEN_W'(1);
            for (int i = 0; i < MAX_PAYLOAD; i++) if (idx == LEN_W'(i)) pbuf[i] <= data;
          end
          default: ;
        endcase
    end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic          active;
  logic [TW-1:0] tcnt;
  assign active = state inside {CMD, LEN, PAYLOAD, CHK};
  assign tout   = active && !stb && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) tcnt <= '0;
    else tcnt <= (!active || stb || tout) ? '0 : tcnt + TW'(1);
`else
  // no timeout hardware: always 0
  assign tout = TIMEOUT_CYCLES < 0;
`endif

  assign bus.frame_valid = state == HOLD;
  assign bus.frame_cmd   = cmd;
  assign bus.frame_len   = len;
  assign bus.err_chk     = r_chk;
  assign bus.err_len     = r_len;
  assign bus.err_overrun = r_ovr;
  assign bus.err_timeout = r_tmo;
  assign bus.err_count   = cnt;
  for (genvar g = 0; g < MAX_PAYLOAD; g++) begin : g_pay
    assign bus.frame_payload[8*g +: 8] = pbuf[g];
  end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed and randomized frames against a frame-level model of the sequencer.
module tb_uart_frame_ctrl;
  localparam int MP = 8;
  localparam int CW = 8;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_frame_ctrl_if #(.MAX_PAYLOAD(MP), .ERR_CNT_W(CW)) bus ();
  uart_frame_ctrl #(.MAX_PAYLOAD(MP), .SYNC_BYTE(8'hA5), .ERR_CNT_W(CW), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0, failures = 0;
  int n_chk = 0, n_len = 0, n_ovr = 0, n_tmo = 0, n_frm = 0;
  int x_chk = 0, x_len = 0, x_ovr = 0, x_tmo = 0, x_frm = 0, x_cnt = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    n_chk += int'(bus.err_chk);
    n_len += int'(bus.err_len);
    n_ovr += int'(bus.err_overrun);
    n_tmo += int'(bus.err_timeout);
    n_frm += int'(bus.frame_valid & ~prev_valid);
    prev_valid = bus.frame_valid;
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bump(int c);
    return (c == SAT) ? c : c + 1;
  endfunction

  task automatic check_errs();
    @(negedge clk);
    #1;
    check("err_chk_pulses", 64'(n_chk), 64'(x_chk));
    check("err_len_pulses", 64'(n_len), 64'(x_len));
    check("err_overrun_pulses", 64'(n_ovr), 64'(x_ovr));
    check("err_timeout_pulses", 64'(n_tmo), 64'(x_tmo));
    check("frames_presented", 64'(n_frm), 64'(x_frm));
    check("err_count", 64'(bus.err_count), 64'(x_cnt));
  endtask

  task automatic send(logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    bus.rx_ready = 1'b0;
    repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic garbage(int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send(b);
    end
    check_errs();
  endtask

  task automatic bad_len(int len);
    send(8'hA5);
    send(8'($urandom));
    send(8'(len));
    x_len++;
    x_cnt = bump(x_cnt);
    check_errs();
  endtask

  // Whole frame: expected checksum and visible payload are derived here from the frame rules.
  task automatic do_frame(logic [7:0] cmd, int len, logic [63:0] pay, bit bad, int ovr, bit simul, bit sticky);
    logic [7:0]  x;
    logic [63:0] p;
    x = cmd ^ 8'(len);
    p = '0;
    for (int i = 0; i < len; i++) begin
      p[8*i +: 8] = pay[8*i +: 8];
      x ^= pay[8*i +: 8];
    end
    if (bad) x ^= 8'($urandom_range(1, 255));
    if (sticky) begin
      @(negedge clk);
      bus.rx_data  = 8'hA5;
      bus.rx_ready = 1'b1;
      @(negedge clk) bus.rx_data = 8'h3C;
      @(negedge clk) bus.rx_data = 8'h5A;
      @(negedge clk) bus.rx_ready = 1'b0;
      @(negedge clk);
    end else send(8'hA5);
    send(cmd);
    send(8'(len));
    for (int i = 0; i < len; i++) send(p[8*i +: 8]);
    @(negedge clk);
    bus.rx_data  = x;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    check("valid_early", 64'(bus.frame_valid), 64'(0));
    @(negedge clk);
    bus.rx_ready = 1'b0;
    if (bad) begin
      check("bad_chk_no_valid", 64'(bus.frame_valid), 64'(0));
      x_chk++;
      x_cnt = bump(x_cnt);
      check_errs();
      return;
    end
    x_frm++;
    check("valid", 64'(bus.frame_valid), 64'(1));
    check("cmd", 64'(bus.frame_cmd), 64'(cmd));
    check("len", 64'(bus.frame_len), 64'(len));
    check("payload", bus.frame_payload, p);
    for (int i = 0; i < ovr; i++) begin
      send(i == 0 ? 8'hA5 : 8'($urandom));
      x_ovr++;
      x_cnt = bump(x_cnt);
    end
    repeat ($urandom_range(0, 5)) @(negedge clk);
    check("hold_valid", 64'(bus.frame_valid), 64'(1));
    check("hold_cmd", 64'(bus.frame_cmd), 64'(cmd));
    check("hold_len", 64'(bus.frame_len), 64'(len));
    check("hold_payload", bus.frame_payload, p);
    if (simul) begin
      @(negedge clk);
      bus.rx_data  = 8'($urandom);
      bus.rx_ready = 1'b1;
      @(negedge clk) bus.frame_ready = 1'b1;
      @(negedge clk);
      bus.frame_ready = 1'b0;
      bus.rx_ready    = 1'b0;
      x_ovr++;
      x_cnt = bump(x_cnt);
    end else begin
      @(negedge clk) bus.frame_ready = 1'b1;
      @(negedge clk) bus.frame_ready = 1'b0;
    end
    check("release_valid", 64'(bus.frame_valid), 64'(0));
    check_errs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1);
  end

  initial begin
    logic [63:0] pay;
    int          k;
    bus.rx_data     = '0;
    bus.rx_ready    = 1'b0;
    bus.frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.frame_valid), 64'(0));
    check("rst_count", 64'(bus.err_count), 64'(0));
    check("rst_payload", bus.frame_payload, 64'(0));
    reset = 1'b0;

    do_frame(8'h10, 2, 64'h2211, 1'b0, 0, 1'b0, 1'b0);
    do_frame(8'h07, 0, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    do_frame(8'h10, 2, 64'h2211, 1'b1, 0, 1'b0, 1'b0);
    bad_len(9);
    do_frame(8'h01, 1, 64'hFF, 1'b0, 0, 1'b0, 1'b0);
    send(8'h00);
    send(8'h13);
    send(8'hA4);
    check_errs();
    do_frame(8'h42, 3, 64'h00C0FFEE, 1'b0, 0, 1'b0, 1'b1);
    do_frame(8'h99, MP, 64'h0123456789ABCDEF, 1'b0, 2, 1'b1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      pay = {$urandom, $urandom};
      k   = $urandom_range(0, 4);
      if (k <= 1) do_frame(8'($urandom), $urandom_range(0, MP), pay, 1'b0, $urandom_range(0, 2), 1'($urandom), 1'b0);
      else if (k == 2) do_frame(8'($urandom), $urandom_range(0, MP), pay, 1'b1, 0, 1'b0, 1'b0);
      else if (k == 3) bad_len($urandom_range(MP + 1, 255));
      else garbage($urandom_range(1, 4));
    end

    do_frame(8'h55, 4, {$urandom, $urandom}, 1'b0, SAT + 5, 1'b0, 1'b0);
    check("err_count_saturated", 64'(bus.err_count), 64'(SAT));
    bad_len(200);

`ifdef UART_FRAME_TIMEOUT_EN
    send(8'hA5);
    send(8'h10);
    repeat (60) @(negedge clk);
    x_tmo++;
    x_cnt = bump(x_cnt);
    check_errs();
    do_frame(8'h21, 2, 64'h3344, 1'b0, 0, 1'b0, 1'b0);
`endif

    send(8'hA5);
    send(8'h10);
    send(8'h03);
    send(8'h11);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", 64'(bus.frame_valid), 64'(0));
    check("midrst_cmd", 64'(bus.frame_cmd), 64'(0));
    check("midrst_len", 64'(bus.frame_len), 64'(0));
    check("midrst_payload", bus.frame_payload, 64'(0));
    check("midrst_count", 64'(bus.err_count), 64'(0));
    x_cnt = 0;
    reset = 1'b0;
    do_frame(8'h66, 2, 64'h7788, 1'b0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
